// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory.
// Size codes, controller states, captured-command bundle, lane/extend helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Request fields held from acceptance until the access edge.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  lo;
        logic [31:0] wdata;
    } cmd_t;

    function automatic logic [3:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << addr_lo;
            SZ_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  addr_lo,
        input logic        unsigned_ld
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{~unsigned_ld & b[7]}}, b};
            SZ_HALF: r = {{16{~unsigned_ld & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word array with per-byte write enables and a registered read port.
// Ports: clk, we/re strobes, be lanes, idx word index, wdata in, rdata out.
module dmem_byte_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // rdata_q only moves on a read strobe, so it keeps the last loaded word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: req/ready/done handshake, wait states, fault flags.
// Ports: clk, rst, req/wr/size/unsigned_ld/address/write_data in; ready, done, read_data, misalign_err, range_err out.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic              ready,
    output logic              done,
    output logic [31:0]       read_data,
    output logic              misalign_err,
    output logic              range_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);
    localparam logic [IDX_W:0] DEPTH_L = DEPTH_WORDS[IDX_W:0];

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             mis_q, mis_d;
    logic             rng_q, rng_d;
    logic             ld_q, ld_d;
    logic [31:0]      rdata_q, rdata_d;
    cmd_t             cmd_q, cmd_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             idle, access, bad_mis, bad_rng;
    logic             op_wr;
    logic [1:0]       op_size, op_lo;
    logic [IDX_W-1:0] op_idx, in_idx;
    logic [31:0]      op_wdata, ram_wdata, ram_rdata, ld_val;

    assign idle   = (state_q == IDLE);
    assign in_idx = address[2 +: IDX_W];

    assign bad_mis = (size == SZ_HALF && address[0])
                   | (size == SZ_WORD && address[1:0] != 2'b00)
                   | (size == 2'b11);
    assign bad_rng = ((address >> (IDX_W + 2)) != '0)
                   | ({1'b0, in_idx} >= DEPTH_L);

    // With zero wait states the access happens on the acceptance edge,
    // so the array is driven from the live inputs while idle.
    assign op_wr    = idle ? wr : cmd_q.wr;
    assign op_size  = idle ? size : cmd_q.size;
    assign op_lo    = idle ? address[1:0] : cmd_q.lo;
    assign op_idx   = idle ? in_idx : idx_q;
    assign op_wdata = idle ? write_data : cmd_q.wdata;

    always_comb begin
        case (op_size)
            SZ_BYTE: ram_wdata = {4{op_wdata[7:0]}};
            SZ_HALF: ram_wdata = {2{op_wdata[15:0]}};
            default: ram_wdata = op_wdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        rng_d   = 1'b0;
        ld_d    = 1'b0;
        rdata_d = rdata_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    cmd_d = '{wr: wr, size: size, uns: unsigned_ld,
                              lo: address[1:0], wdata: write_data};
                    idx_d = in_idx;
                    if (bad_mis || bad_rng) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        mis_d   = bad_mis;
                        rng_d   = bad_rng;
                    end else if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        state_d = RESP;
                        done_d  = 1'b1;
                        ld_d    = ~wr;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_L;
                    end
                end
            end
            WAIT: begin
                // cnt_q counts remaining wait cycles including this one.
                if (cnt_q <= 4'd1) begin
                    access  = 1'b1;
                    state_d = RESP;
                    done_d  = 1'b1;
                    ld_d    = ~cmd_q.wr;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (ld_q) begin
                    rdata_d = ld_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
            ld_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            rng_q   <= rng_d;
            ld_q    <= ld_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        cmd_q <= cmd_d;
        idx_q <= idx_d;
    end

    dmem_byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk  (clk),
        .we   (access & op_wr & ~rst),
        .re   (access & ~op_wr & ~rst),
        .be   (lane_mask(op_size, op_lo)),
        .idx  (op_idx),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // The RAM word lands after the access edge; extend it for the done
    // cycle, then hold the extended value in rdata_q.
    assign ld_val = load_extend(ram_rdata, cmd_q.size, cmd_q.lo, cmd_q.uns);

    assign ready        = idle;
    assign done         = done_q;
    assign read_data    = ld_q ? ld_val : rdata_q;
    assign misalign_err = mis_q;
    assign range_err    = rng_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl with WAIT_CYCLES of 1, 3 and 0.
// Expected responses are queued at issue and popped at done.
module tb_data_memory_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic [1:0]  size = SZ_WORD;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        reqv [3];
    logic        rdy [3];
    logic        dn [3];
    logic        me [3];
    logic        rg [3];
    logic [31:0] rd [3];

    int checks = 0;
    int failures = 0;
    int step = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        mis;
        logic        rng;
        logic [7:0]  lat;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(1), .ADDR_W(32)) u_w1 (
        .clk(clk), .rst(rst), .req(reqv[0]), .wr(wr), .size(size),
        .unsigned_ld(uns), .address(addr), .write_data(wdata),
        .ready(rdy[0]), .done(dn[0]), .read_data(rd[0]),
        .misalign_err(me[0]), .range_err(rg[0])
    );

    data_memory_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(3), .ADDR_W(32)) u_w3 (
        .clk(clk), .rst(rst), .req(reqv[1]), .wr(wr), .size(size),
        .unsigned_ld(uns), .address(addr), .write_data(wdata),
        .ready(rdy[1]), .done(dn[1]), .read_data(rd[1]),
        .misalign_err(me[1]), .range_err(rg[1])
    );

    data_memory_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_W(32)) u_w0 (
        .clk(clk), .rst(rst), .req(reqv[2]), .wr(wr), .size(size),
        .unsigned_ld(uns), .address(addr), .write_data(wdata),
        .ready(rdy[2]), .done(dn[2]), .read_data(rd[2]),
        .misalign_err(me[2]), .range_err(rg[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic acc(input int k, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] erd,
                       input logic emis, input logic erng, input int lat,
                       input bit poke);
        exp_t  e;
        int    n;
        string t;
        step++;
        t = $sformatf("s%0d", step);
        sb.push_back('{rd: erd, mis: emis, rng: erng, lat: 8'(lat)});
        @(negedge clk);
        wr = w; size = sz; uns = u; addr = a; wdata = wd;
        reqv[k] = 1'b1;
        chk1({t, ".ready"}, rdy[k], 1'b1);
        @(posedge clk); #1;
        reqv[k] = 1'b0;
        chk1({t, ".busy"}, rdy[k], 1'b0);
        n = 1;
        if (poke) begin
            reqv[k] = 1'b1; wr = ~w; addr = a ^ 32'h4; wdata = ~wd;
            @(posedge clk); #1;
            reqv[k] = 1'b0;
            n = 2;
            chk1({t, ".poke"}, rdy[k], 1'b0);
        end
        while (!dn[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        chk({t, ".lat"}, 32'(n), 32'(e.lat));
        chk({t, ".rd"}, rd[k], e.rd);
        chk1({t, ".mis"}, me[k], e.mis);
        chk1({t, ".rng"}, rg[k], e.rng);
        chk1({t, ".rdy_d"}, rdy[k], 1'b0);
        @(posedge clk); #1;
        chk1({t, ".pulse"}, dn[k], 1'b0);
        chk1({t, ".idle"}, rdy[k], 1'b1);
        chk1({t, ".flags"}, me[k] | rg[k], 1'b0);
        chk({t, ".hold"}, rd[k], e.rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] dpat;
        logic [5:0] rpat;
        int dcount;
        for (int i = 0; i < 3; i++) reqv[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk1("rst.ready", rdy[i], 1'b1);
            chk1("rst.done", dn[i], 1'b0);
            chk("rst.rd", rd[i], 32'h0);
            chk1("rst.mis", me[i], 1'b0);
            chk1("rst.rng", rg[i], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // WAIT_CYCLES=1 instance
        acc(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 2, 0);
        acc(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 2, 0);
        acc(0, 1, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 2, 0);
        acc(0, 1, SZ_BYTE, 0, 32'h13, 32'h12345680, 32'hDEADBEEF, 0, 0, 2, 0);
        acc(0, 0, SZ_BYTE, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 0, 2, 0);
        acc(0, 0, SZ_BYTE, 1, 32'h13, 32'h0, 32'h00000080, 0, 0, 2, 0);
        acc(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h80000000, 0, 0, 2, 0);
        acc(0, 0, SZ_HALF, 0, 32'h11, 32'h0, 32'h80000000, 1, 0, 1, 0);
        acc(0, 1, SZ_WORD, 0, 32'h12, 32'hCAFEF00D, 32'h80000000, 1, 0, 1, 0);
        acc(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h80000000, 0, 0, 2, 0);
        acc(0, 1, SZ_HALF, 0, 32'h12, 32'h1234BEEF, 32'h80000000, 0, 0, 2, 0);
        acc(0, 0, SZ_HALF, 0, 32'h12, 32'h0, 32'hFFFFBEEF, 0, 0, 2, 0);
        acc(0, 0, SZ_HALF, 1, 32'h12, 32'h0, 32'h0000BEEF, 0, 0, 2, 0);
        acc(0, 1, SZ_WORD, 0, 32'h0, 32'h11223344, 32'h0000BEEF, 0, 0, 2, 0);
        acc(0, 0, SZ_WORD, 0, 32'h400, 32'h0, 32'h0000BEEF, 0, 1, 1, 0);
        acc(0, 1, SZ_WORD, 0, 32'h400, 32'h55667788, 32'h0000BEEF, 0, 1, 1, 0);
        acc(0, 0, SZ_WORD, 0, 32'h0, 32'h0, 32'h11223344, 0, 0, 2, 0);
        acc(0, 0, SZ_BYTE, 1, 32'h1, 32'h0, 32'h00000033, 0, 0, 2, 0);
        acc(0, 0, SZ_HALF, 0, 32'h2, 32'h0, 32'h00001122, 0, 0, 2, 0);
        acc(0, 1, SZ_WORD, 0, 32'h80000010, 32'h0, 32'h00001122, 0, 1, 1, 0);
        acc(0, 0, SZ_WORD, 0, 32'h401, 32'h0, 32'h00001122, 1, 1, 1, 0);
        acc(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h00001122, 1, 0, 1, 0);
        acc(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hBEEF0000, 0, 0, 2, 0);
        acc(0, 1, SZ_BYTE, 0, 32'h11, 32'h0000007F, 32'hBEEF0000, 0, 0, 2, 0);
        acc(0, 0, SZ_HALF, 0, 32'h10, 32'h0, 32'h00007F00, 0, 0, 2, 0);

        // WAIT_CYCLES=0 instance
        acc(2, 1, SZ_WORD, 0, 32'h4, 32'hA5A5A5A5, 32'h0, 0, 0, 1, 0);
        acc(2, 0, SZ_WORD, 0, 32'h4, 32'h0, 32'hA5A5A5A5, 0, 0, 1, 0);
        acc(2, 0, SZ_BYTE, 0, 32'h5, 32'h0, 32'hFFFFFFA5, 0, 0, 1, 0);
        @(negedge clk);
        wr = 1'b0; size = SZ_WORD; uns = 1'b0; addr = 32'h4;
        reqv[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            dpat[i] = dn[2];
            rpat[i] = rdy[2];
        end
        reqv[2] = 1'b0;
        chk("b2b.done", 32'(dpat), 32'h15);
        chk("b2b.ready", 32'(rpat), 32'h2A);
        chk("b2b.rd", rd[2], 32'hA5A5A5A5);

        // WAIT_CYCLES=3 instance
        acc(1, 1, SZ_WORD, 0, 32'h20, 32'h0BADF00D, 32'h0, 0, 0, 4, 0);
        acc(1, 0, SZ_WORD, 0, 32'h20, 32'h0, 32'h0BADF00D, 0, 0, 4, 1);

        @(negedge clk);
        wr = 1'b1; size = SZ_WORD; addr = 32'h20; wdata = 32'hFFFFFFFF;
        reqv[1] = 1'b1;
        @(posedge clk); #1;
        reqv[1] = 1'b0;
        chk1("abort.busy", rdy[1], 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk1("abort.done", dn[1], 1'b0);
        chk1("abort.ready", rdy[1], 1'b1);
        @(negedge clk);
        reqv[1] = 1'b1;
        @(posedge clk); #1;
        chk1("rstreq.ready", rdy[1], 1'b1);
        @(negedge clk);
        rst = 1'b0;
        reqv[1] = 1'b0;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (dn[1]) dcount++;
        end
        chk("abort.nodone", 32'(dcount), 32'h0);
        chk("rst2.rd0", rd[0], 32'h0);
        chk("rst2.rd1", rd[1], 32'h0);
        chk("rst2.rd2", rd[2], 32'h0);
        acc(1, 0, SZ_WORD, 0, 32'h20, 32'h0, 32'h0BADF00D, 0, 0, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised, byte-addressed data memory for the single-issue CPU datapath. It succeeds the plain word memory with three additions: byte, half and word stores via byte-lane enables; sign- or zero-extended sub-word loads; and a req/ready/done handshake with a programmable wait-state counter, so it can model slower memory. Misaligned and out-of-range accesses are flagged and never touch the array.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; word index = address[2+:IDX_W], with IDX_W = clog2(DEPTH_WORDS).
WAIT_CYCLES, 1, extra cycles between acceptance and array access; legal range 0..15.
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req  in  1  access request; sampled only while ready=1
wr  in  1  1=store, 0=load; captured with req
size  in  2  00=byte, 01=half, 10=word, 11=illegal
unsigned_ld  in  1  1=zero-extend a sub-word load, 0=sign-extend
address  in  ADDR_W  byte address
write_data  in  32  store data; byte/half taken from bits [7:0]/[15:0]
ready  out  1  high in IDLE only; a request is accepted on a clk edge where req&ready
done  out  1  one-cycle completion pulse
read_data  out  32  load result; valid while done=1 for a load; holds until the next load completes
misalign_err  out  1  valid with done; alignment fault or size=11
range_err  out  1  valid with done; word index >= DEPTH_WORDS

Behaviour:
- Reset: synchronous, active-high. On rst: state=IDLE, done=0, read_data=0, misalign_err=0, range_err=0, wait counter=0. ready=1 from the first cycle after reset. Array contents are not reset.
- States and transitions:
  - IDLE -> WAIT on acceptance (edge T0). Captures wr, size, unsigned_ld, address and write_data; loads counter=WAIT_CYCLES.
  - WAIT: counter decrements each cycle. When counter==0, the access is performed at that edge and the state moves to RESP.
  - RESP: done=1 for exactly one cycle, then IDLE.
- Latency: done is high during cycle T0+WAIT_CYCLES+1, measured in clock edges after acceptance. With WAIT_CYCLES=0, done is high the cycle after acceptance.
- Fault check at acceptance:
  - misaligned = (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | size==11.
  - out of range = word index >= DEPTH_WORDS, or any address bit above index bits [IDX_W+1] set.
  - On a fault: skip WAIT and go directly to RESP (done at T0+1) with the matching error flag(s); no array write; read_data unchanged.
- Error flags are high only during the done cycle; otherwise 0. Both flags may be high together.
- Store: per-byte lane enables from size and addr[1:0].
  - byte: lane addr[1:0] gets write_data[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} get write_data[15:0], little-endian.
  - word: all lanes.
  - Unselected lanes are preserved. read_data is unchanged by stores.
- Load: the word is read at the access edge; the lane is selected by addr[1:0], extended per unsigned_ld, and registered into read_data so it is valid in the done cycle.
- req while ready=0 is ignored. There is no queueing; the master must hold or re-issue the request.
- Inputs are captured at acceptance; input changes during WAIT have no effect.
- rst during WAIT or RESP: abort. A store whose access edge has not occurred is not performed; no done pulse.
- rst and req on the same edge: reset wins; the request is not accepted.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state enum {IDLE, WAIT, RESP};
  - function lane_mask(size, addr_lo) returning [3:0];
  - function load_extend(word, size, addr_lo, unsigned_ld).
- Sub-module dmem_byte_ram: DEPTH_WORDS x 32 array, synchronous write with 4-bit byte enable, registered read. The controller FSM sits in data_memory_ctrl.

Test Plan:
- WAIT_CYCLES=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> each done at T0+2; read_data=0xDEADBEEF; no errors.
- Store byte 0x80 @0x13 over 0x00000000, then load byte @0x13 signed -> 0xFFFFFF80; load byte @0x13 unsigned -> 0x00000080; load word @0x10 -> 0x80000000.
- Load half @0x11 -> done at T0+1 with misalign_err=1 and read_data unchanged; store word @0x12 -> misalign_err=1; a following word load @0x10 shows the old value.
- DEPTH_WORDS=256: load word @0x400 -> range_err=1; store word @0x400 -> range_err=1 and word 0 is unmodified.
- WAIT_CYCLES=3: store @0x20, assert rst at T0+2 -> no done; load @0x20 after reset returns the pre-store value. Also pulse req during WAIT -> ignored and ready stays 0.
- WAIT_CYCLES=0: back-to-back requests -> accept, done, accept every 2 cycles; ready=0 exactly during WAIT/RESP.
